// File: rtl/matrix_mult_sequencer.sv
// Sequences a 2x2 by 2x2 8-bit matrix multiply through one shared 8x8 multiplier.
// Define MATRIX_MULT_SEQ_SATURATE_EN to saturate products and sums at 8'hFF instead of wrapping.
module matrix_mult_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] c,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

   state_t      state;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] p;
   logic [2:0]  idx;

   // idx[2] picks the A row, idx[1] the B column and idx[0] the inner term.
   logic [1:0]  a_sel;
   logic [1:0]  b_sel;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [7:0]  prod;

   assign a_sel = {idx[2], idx[0]};
   assign b_sel = {idx[0], idx[1]};
   assign op_a  = a_q[8*a_sel +: 8];
   assign op_b  = b_q[8*b_sel +: 8];

`ifdef MATRIX_MULT_SEQ_SATURATE_EN
   logic [15:0] prod_full;
   assign prod_full = op_a * op_b;
   assign prod      = (prod_full[15:8] != 8'h00) ? 8'hFF : prod_full[7:0];

   function automatic logic [7:0] pair_add(input logic [7:0] x, input logic [7:0] y);
      logic [8:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[8] ? 8'hFF : s[7:0];
   endfunction
`else
   assign prod = op_a * op_b;

   function automatic logic [7:0] pair_add(input logic [7:0] x, input logic [7:0] y);
      return x + y;
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         c         <= '0;
         p         <= '0;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= MUL;
               end
            end
            MUL: begin
               p[8*idx +: 8] <= prod;
               idx           <= idx + 3'd1;
               if (idx == 3'd7) begin
                  state <= ADD;
               end
            end
            ADD: begin
               c <= {pair_add(p[55:48], p[63:56]),
                     pair_add(p[39:32], p[47:40]),
                     pair_add(p[23:16], p[31:24]),
                     pair_add(p[7:0],   p[15:8])};
               busy      <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed scoreboard bench for matrix_mult_sequencer; expected results queued at accept.
module tb_matrix_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] c;
   logic        busy;

   int unsigned total_cnt = 0;
   int unsigned pass_cnt  = 0;
   logic [31:0] exp_q[$];

   matrix_mult_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents operands for one edge (the accept edge E0) and queues the expected result.
   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
      check("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      exp_q.push_back(exp);
      check("busy_after_accept", busy, 1);
      check("in_ready_after_accept", in_ready, 0);
   endtask

   // Waits for out_valid, checks latency and result, holds out_ready low for hold cycles.
   task automatic receive(input int exp_lat, input int hold);
      int n;
      logic [31:0] held;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check("latency", n, exp_lat);
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
      end else begin
         check("result_c", c, exp_q.pop_front());
      end
      check("busy_in_done", busy, 0);
      check("in_ready_in_done", in_ready, 0);
      held = c;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = $urandom;
         b        = $urandom;
         tick();
         check("hold_out_valid", out_valid, 1);
         check("hold_c_stable", c, held);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_c", c, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Mixed operands with exact latency
      send(32'h04030201, 32'h08070605, 32'h322B1613);
      receive(9, 0);

      // Identity
      send(32'h01000001, 32'h04030201, 32'h04030201);
      receive(9, 0);

      // Overflow
`ifdef MATRIX_MULT_SEQ_SATURATE_EN
      send(32'h10101010, 32'h10101010, 32'hFFFFFFFF);
`else
      send(32'h10101010, 32'h10101010, 32'h00000000);
`endif
      receive(9, 0);

      // Backpressure: 5 cycles with out_ready low and in_valid pushing junk
      send(32'h04030201, 32'h08070605, 32'h322B1613);
      receive(9, 5);
      send(32'h01000001, 32'hDEADBEEF, 32'hDEADBEEF);
      receive(9, 0);

      // New operands during MUL are ignored
      send(32'h04030201, 32'h08070605, 32'h322B1613);
      tick();
      in_valid = 1'b1;
      a        = 32'hFFFFFFFF;
      b        = 32'h11111111;
      tick();
      check("in_ready_during_mul", in_ready, 0);
      a = 32'h01010101;
      tick();
      in_valid = 1'b0;
      receive(6, 0);

      // Asynchronous reset at idx=4 discards the operation
      send(32'h10203040, 32'h05060708, 32'h0);
      repeat (4) tick();
      check("busy_mid_op", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_busy", busy, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_c", c, 32'h0);
      void'(exp_q.pop_back());
      tick();
      rst = 1'b0;
      tick();
      send(32'h04030201, 32'h08070605, 32'h322B1613);
      receive(9, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
